// File: rtl/gcd32_dispatch.sv
// gcd32_fifo: generic first-word-fall-through FIFO, DEPTH entries of WIDTH bits.
// Latency: a push is visible on rdat/empty one edge later; pop takes effect at the edge.
// Backpressure: full blocks further pushes, and a pop in the same cycle does not clear full.
module gcd32_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdat,
    input  logic             pop,
    output logic [WIDTH-1:0] rdat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdat    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// gcd32_dispatch: queues operand pairs, issues them one at a time to a GCD core, returns results.
// Latency: 3 edges push-to-out_valid when the core answers at once; 1 edge for zero operands.
// Backpressure: out_ready low holds RESULT and stalls the core path; in_ready drops when FIFO full.
module gcd32_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    output logic        in_ready,
    output logic [31:0] core_x,
    output logic [31:0] core_y,
    output logic        core_start,
    input  logic        core_done,
    input  logic [31:0] core_gcd,
    output logic        out_valid,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic [31:0] out_gcd,
    output logic        out_err,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] job_count
);
    localparam int TW = $clog2(TIMEOUT);

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
    } pair_t;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESULT} state_t;

    state_t        state;
    state_t        state_nxt;
    pair_t         in_pair;
    pair_t         head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop_head;
    logic          head_zero;
    logic          timeout_hit;
    logic [31:0]   x_reg;
    logic [31:0]   y_reg;
    logic [31:0]   gcd_reg;
    logic          err_reg;
    logic [TW-1:0] timer;

    assign in_pair = '{x: in_x, y: in_y};

    gcd32_fifo #(.WIDTH($bits(pair_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .wdat  (in_pair),
        .pop   (pop_head),
        .rdat  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Gate with reset so the producer never sees ready while state is being cleared.
    assign in_ready    = !fifo_full && !reset;
    assign head_zero   = (head.x == 32'd0) || (head.y == 32'd0);
    assign timeout_hit = (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!fifo_empty) state_nxt = head_zero ? S_RESULT : S_START;
            S_START:  state_nxt = S_WAIT;
            S_WAIT:   if (core_done || timeout_hit) state_nxt = S_RESULT;
            S_RESULT: if (out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pop_head   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE:   pop_head   = !fifo_empty;
            S_START:  core_start = 1'b1;
            S_RESULT: out_valid  = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg     <= '0;
            y_reg     <= '0;
            gcd_reg   <= '0;
            err_reg   <= 1'b0;
            timer     <= '0;
            job_count <= '0;
        end else begin
            if (pop_head) begin
                x_reg <= head.x;
                y_reg <= head.y;
                if (head_zero) begin
                    gcd_reg <= head.x | head.y;
                    err_reg <= 1'b0;
                end
            end
            if (state == S_START) begin
                timer <= '0;
            end else if (state == S_WAIT) begin
                timer <= timer + TW'(1);
                if (core_done) begin
                    gcd_reg <= core_gcd;
                    err_reg <= 1'b0;
                end else if (timeout_hit) begin
                    gcd_reg <= '0;
                    err_reg <= 1'b1;
                end
            end
            if (out_valid && out_ready) job_count <= job_count + 16'd1;
        end
    end

    assign core_x  = x_reg;
    assign core_y  = y_reg;
    assign out_x   = x_reg;
    assign out_y   = y_reg;
    assign out_gcd = gcd_reg;
    assign out_err = err_reg;
    assign busy    = (state != S_IDLE) || !fifo_empty;
endmodule
